// File: rtl/digit_scan_scheduler_pkg.sv
// Shared types, constants and helpers for the six-digit display scan scheduler.
package digit_scan_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 4;
    localparam int SNAP_W     = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W      = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Digit 0 is the leftmost nibble [23:20]; digit 5 is [3:0].
    function automatic logic [DIGIT_W-1:0] digit_nibble(input logic [SNAP_W-1:0] snapshot,
                                                        input logic [IDX_W-1:0]  idx);
        if (int'(idx) >= NUM_DIGITS) begin
            return '0;
        end
        return snapshot[(SNAP_W - 1) - DIGIT_W * int'(idx) -: DIGIT_W];
    endfunction

    // One-hot-low select: bit idx low, all others high.
    function automatic logic [NUM_DIGITS-1:0] digit_select_n(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/digit_scan_scheduler_if.sv
// Bus between the timekeeping/setting logic, the scan scheduler and the digit drivers.
interface digit_scan_scheduler_if;
    import digit_scan_pkg::*;

    logic                  en;
    logic [SNAP_W-1:0]     number_sig;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [NUM_DIGITS-1:0] dig_sel_n;
    logic [DIGIT_W-1:0]    number_data;
    logic                  frame_start;

    // Driver side: supplies the time word and controls, observes the display outputs.
    modport master (
        output en, number_sig, blink_mask,
        input  dig_sel_n, number_data, frame_start
    );

    // Scheduler side.
    modport slave (
        input  en, number_sig, blink_mask,
        output dig_sel_n, number_data, frame_start
    );

endinterface

// File: rtl/digit_scan_scheduler_interval_counter.sv
// Up-counter with a selectable terminal value; wraps to zero on terminal count.
module interval_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_last,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    assign o_tc    = (r_count == i_last);
    assign o_count = r_count;

    // Count up while enabled; terminal count or an explicit clear returns to zero.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (o_tc) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/digit_scan_scheduler.sv
// Time-multiplexed scan of the six-digit BCD display with dead-time and blinking.
module digit_scan_scheduler
    import digit_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digit_scan_scheduler_if.slave bus
);

    localparam int MAX_IV = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W  = (MAX_IV > 1) ? $clog2(MAX_IV) : 1;
    localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(BLINK_FRAMES - 1);

    scan_state_t           r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [SNAP_W-1:0]     r_snapshot;
    logic [NUM_DIGITS-1:0] r_mask;
    logic [FC_W-1:0]       r_frame_cnt;
    logic                  r_blink_phase;
    logic [NUM_DIGITS-1:0] r_dig_sel_n;
    logic [DIGIT_W-1:0]    r_number_data;
    logic                  r_frame_start;

    logic [CNT_W-1:0]      w_cnt;
    logic                  w_tc;
    logic [CNT_W-1:0]      w_last;
    logic                  w_origin;
    logic                  w_run;
    logic                  w_clear;

    scan_state_t           w_next_state;
    logic [IDX_W-1:0]      w_next_idx;
    logic [SNAP_W-1:0]     w_next_snapshot;
    logic [NUM_DIGITS-1:0] w_next_mask;
    logic [FC_W-1:0]       w_next_frame_cnt;
    logic                  w_next_phase;
    logic                  w_frame_wrap;
    logic                  w_next_hidden;
    logic                  w_next_frame_start;

    // Origin of the frame: first BLANK cycle of digit 0. After reset or a disable the
    // scan parks here for one cycle so the frame_start register can announce the frame.
    assign w_origin = (r_state == BLANK) && (r_idx == '0) && (w_cnt == '0);
    assign w_run    = bus.en && !(w_origin && !r_frame_start);
    assign w_clear  = !bus.en;
    assign w_last   = (r_state == BLANK) ? BLANK_LAST : DWELL_LAST;

    interval_counter #(
        .WIDTH (CNT_W)
    ) u_interval_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_enable (w_run),
        .i_last   (w_last),
        .o_count  (w_cnt),
        .o_tc     (w_tc)
    );

    // Next-state, snapshot capture and frame/blink divider, evaluated for the coming edge.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_next_state     = r_state;
        w_next_idx       = r_idx;
        w_next_snapshot  = r_snapshot;
        w_next_mask      = r_mask;
        w_next_frame_cnt = r_frame_cnt;
        w_next_phase     = r_blink_phase;
        w_frame_wrap     = 1'b0;

        if (!bus.en) begin
            w_next_state = BLANK;
            w_next_idx   = '0;
        end else if (w_run) begin
            if (w_origin) begin
                w_next_snapshot = bus.number_sig;
                w_next_mask     = bus.blink_mask;
            end
            if (w_tc) begin
                if (r_state == BLANK) begin
                    w_next_state = SHOW;
                end else begin
                    w_next_state = BLANK;
                    if (r_idx == LAST_IDX) begin
                        w_next_idx   = '0;
                        w_frame_wrap = 1'b1;
                        if (r_frame_cnt == FRAME_LAST) begin
                            w_next_frame_cnt = '0;
                            w_next_phase     = ~r_blink_phase;
                        end else begin
                            w_next_frame_cnt = r_frame_cnt + FC_W'(1);
                        end
                    end else begin
                        w_next_idx = r_idx + IDX_W'(1);
                    end
                end
            end
        end

        w_next_hidden      = w_next_mask[LAST_IDX - w_next_idx] && w_next_phase;
        w_next_frame_start = bus.en && (w_frame_wrap || (w_origin && !r_frame_start));
    end

    // Scan FSM with registered display outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BLANK;
            r_idx         <= '0;
            r_snapshot    <= '0;
            r_mask        <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_dig_sel_n   <= '1;
            r_number_data <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_idx         <= w_next_idx;
            r_snapshot    <= w_next_snapshot;
            r_mask        <= w_next_mask;
            r_frame_cnt   <= w_next_frame_cnt;
            r_blink_phase <= w_next_phase;
            r_frame_start <= w_next_frame_start;
            r_number_data <= digit_nibble(w_next_snapshot, w_next_idx);
            if ((w_next_state == SHOW) && !w_next_hidden) begin
                r_dig_sel_n <= digit_select_n(w_next_idx);
            end else begin
                r_dig_sel_n <= '1;
            end
        end
    end

    assign bus.dig_sel_n   = r_dig_sel_n;
    assign bus.number_data = r_number_data;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_digit_scan_scheduler.sv
// Directed bench for digit_scan_scheduler with D=4, B=2, BLINK_FRAMES=2 (36-cycle frames).
module tb_digit_scan_scheduler;

    localparam int D = 4;
    localparam int B = 2;
    localparam int BF = 2;
    localparam int SLOT = B + D;
    localparam int FRAME = 6 * SLOT;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    digit_scan_scheduler_if dut_if ();

    digit_scan_scheduler #(
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Checks one full frame starting at the current negedge (frame-relative cycle 0),
    // ending on cycle 0 of the following frame.
    task automatic check_frame(input string name, input logic [23:0] digits, input logic [5:0] hide);
        logic [23:0] d;
        logic [5:0]  exp_sel;
        int slot;
        int off;
        d = digits;
        for (int rel = 0; rel < FRAME; rel++) begin
            if (rel > 0) @(negedge clk);
            slot = rel / SLOT;
            off  = rel % SLOT;
            if (off < B || hide[5 - slot]) exp_sel = 6'h3F;
            else exp_sel = ~(6'b1 << slot);
            check({name, "_sel"}, dut_if.dig_sel_n, exp_sel);
            check({name, "_fs"}, dut_if.frame_start, (rel == 0) ? 1 : 0);
            if (exp_sel != 6'h3F) check({name, "_data"}, dut_if.number_data, d[23 - 4 * slot -: 4]);
        end
        @(negedge clk);
        check({name, "_next_fs"}, dut_if.frame_start, 1);
    endtask

    task automatic wait_frame_start(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (dut_if.frame_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_seen", dut_if.frame_start, 1);
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Whole-run select checker: one-hot-or-off, and >= B all-off cycles between distinct selects.
    initial begin
        logic [5:0] prev_sel;
        int off_run;
        bit have_last;
        prev_sel = 6'h3F;
        off_run = 0;
        have_last = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_last = 0;
                off_run = 0;
            end else begin
                check("sel_onehot", ($countones(~dut_if.dig_sel_n) <= 1) ? 1 : 0, 1);
                if (dut_if.dig_sel_n != 6'h3F) begin
                    if (have_last && dut_if.dig_sel_n != prev_sel)
                        check("sel_gap", (off_run >= B) ? 1 : 0, 1);
                    have_last = 1;
                    prev_sel = dut_if.dig_sel_n;
                    off_run = 0;
                end else begin
                    off_run++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          rel;
        bit          drive;
        logic [23:0] sig;
        logic [5:0]  sel;
        logic [3:0]  data;
        bit          chk_data;
        logic        fs;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int cur;

        vecs[0]  = '{0,  0, 24'h0,      6'h3F, 4'h0, 0, 1'b1};
        vecs[1]  = '{1,  0, 24'h0,      6'h3F, 4'h0, 0, 1'b0};
        vecs[2]  = '{2,  0, 24'h0,      6'h3E, 4'h1, 1, 1'b0};
        vecs[3]  = '{5,  0, 24'h0,      6'h3E, 4'h1, 1, 1'b0};
        vecs[4]  = '{6,  0, 24'h0,      6'h3F, 4'h0, 0, 1'b0};
        vecs[5]  = '{8,  0, 24'h0,      6'h3D, 4'h2, 1, 1'b0};
        vecs[6]  = '{10, 1, 24'h999999, 6'h3D, 4'h2, 1, 1'b0};
        vecs[7]  = '{14, 0, 24'h0,      6'h3B, 4'h3, 1, 1'b0};
        vecs[8]  = '{20, 0, 24'h0,      6'h37, 4'h4, 1, 1'b0};
        vecs[9]  = '{26, 0, 24'h0,      6'h2F, 4'h5, 1, 1'b0};
        vecs[10] = '{31, 0, 24'h0,      6'h3F, 4'h0, 0, 1'b0};
        vecs[11] = '{32, 0, 24'h0,      6'h1F, 4'h6, 1, 1'b0};
        vecs[12] = '{35, 0, 24'h0,      6'h1F, 4'h6, 1, 1'b0};
        vecs[13] = '{36, 0, 24'h0,      6'h3F, 4'h0, 0, 1'b1};

        // Reset state
        rst_n = 1'b0;
        dut_if.en = 1'b0;
        dut_if.number_sig = 24'h123456;
        dut_if.blink_mask = 6'b100001;
        skip(2);
        check("rst_sel", dut_if.dig_sel_n, 6'h3F);
        check("rst_data", dut_if.number_data, 0);
        check("rst_fs", dut_if.frame_start, 0);

        rst_n = 1'b1;
        dut_if.en = 1'b1;
        wait_frame_start(10);

        // Frame 0 from the vector table; number_sig changes mid-frame at cycle 10.
        cur = 0;
        for (int i = 0; i < 14; i++) begin
            while (cur < vecs[i].rel) begin
                @(negedge clk);
                cur++;
            end
            if (vecs[i].drive) dut_if.number_sig = vecs[i].sig;
            check($sformatf("vec%0d_sel", i), dut_if.dig_sel_n, vecs[i].sel);
            check($sformatf("vec%0d_fs", i), dut_if.frame_start, vecs[i].fs);
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_data", i), dut_if.number_data, vecs[i].data);
        end

        // Frames 1..3: new value takes effect; frames 2-3 blank digits 0 and 5.
        check_frame("frame1", 24'h999999, 6'b000000);
        check_frame("frame2", 24'h999999, 6'b100001);
        check_frame("frame3", 24'h999999, 6'b100001);

        // Frame 4 visible again; drop en at cycle 20 for 3 cycles.
        skip(20);
        check("f4_rel20_sel", dut_if.dig_sel_n, 6'h37);
        check("f4_rel20_data", dut_if.number_data, 4'h9);
        dut_if.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("en_low_sel", dut_if.dig_sel_n, 6'h3F);
            check("en_low_fs", dut_if.frame_start, 0);
        end
        dut_if.en = 1'b1;
        @(negedge clk);
        check_frame("restart", 24'h999999, 6'b000000);

        // Reset mid-SHOW of digit 3.
        skip(21);
        check("pre_rst_sel", dut_if.dig_sel_n, 6'h37);
        rst_n = 1'b0;
        dut_if.blink_mask = 6'b000000;
        #1;
        check("async_rst_sel", dut_if.dig_sel_n, 6'h3F);
        check("async_rst_data", dut_if.number_data, 0);
        check("async_rst_fs", dut_if.frame_start, 0);
        skip(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_fs", dut_if.frame_start, 1);
        check("post_rst_snapshot", dut_if.number_data, 0);
        check_frame("post_rst", 24'h999999, 6'b000000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
